// File: rtl/vrf_pkg.sv
// Shared vector register-file constants, the arbitration-pointer type and address helpers.
package vrf_pkg;
  localparam int VLEN    = 256;
  localparam int VADDR_W = 5;
  localparam int NVREG   = 16;
  localparam logic [VADDR_W-1:0] VRF_BASE = 5'h10;

  typedef enum logic {PRI_ALU = 1'b0, PRI_MEM = 1'b1} rr_pri_t;

  // Offsets are formed one bit wider so that base+15 may exceed 5'h1F without wrapping.
  function automatic logic vrf_in_range(input logic [VADDR_W-1:0] addr,
                                        input logic [VADDR_W-1:0] base);
    logic [VADDR_W:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return ({1'b0, addr} >= {1'b0, base}) && (off < (VADDR_W+1)'(NVREG));
  endfunction

  function automatic logic [3:0] vrf_index(input logic [VADDR_W-1:0] addr,
                                           input logic [VADDR_W-1:0] base);
    logic [VADDR_W-1:0] off;
    off = addr - base;
    return off[3:0];
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; req[0]/gnt[0] is the ALU, req[1]/gnt[1] the load unit.
module rr_arb2
  import vrf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  rr_pri_t r_pri;
  rr_pri_t w_pri_nxt;

  // Grants are suppressed during reset; any grant is a transfer, so the pointer moves on it.
  always_comb begin
    gnt       = 2'b00;
    w_pri_nxt = r_pri;
    if (!rst) begin
      if (req == 2'b11) gnt = (r_pri == PRI_ALU) ? 2'b01 : 2'b10;
      else              gnt = req;
    end
    if (gnt[0])      w_pri_nxt = PRI_MEM;
    else if (gnt[1]) w_pri_nxt = PRI_ALU;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pri <= PRI_ALU;
    else     r_pri <= w_pri_nxt;
  end
endmodule

// File: rtl/vrf_wb_arbiter.sv
// Vector register-file write-back arbiter: merges ALU and load-unit writes onto one port
// and tracks pending destination registers as a scoreboard.
module vrf_wb_arbiter
  import vrf_pkg::*;
#(
  parameter int         VLEN     = vrf_pkg::VLEN,
  parameter logic [4:0] VRF_BASE = vrf_pkg::VRF_BASE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_addr,
  input  logic [VLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_addr,
  input  logic [VLEN-1:0] mem_data,
  input  logic            rsv_valid,
  input  logic [4:0]      rsv_addr,
  input  logic [4:0]      chk_addr,
  output logic            chk_busy,
  output logic [15:0]     busy,
  output logic            err,
  output logic            vwe3,
  output logic [4:0]      vwa3,
  output logic [VLEN-1:0] vwd3
);
  logic [1:0]      w_gnt;
  logic            w_xfer;
  logic            w_xfer_inr;
  logic [4:0]      w_xaddr;
  logic [VLEN-1:0] w_xdata;
  logic [3:0]      w_xidx;
  logic            w_rsv_inr;
  logic [3:0]      w_rsv_idx;
  logic [15:0]     w_clr;
  logic [15:0]     w_set;
  logic            w_rsv_err;
  logic [15:0]     w_busy_nxt;

  logic            r_vwe;
  logic [4:0]      r_vwa;
  logic [VLEN-1:0] r_vwd;
  logic [15:0]     r_busy;
  logic            r_err;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({mem_valid, alu_valid}),
    .gnt (w_gnt)
  );

  assign alu_ready  = w_gnt[0];
  assign mem_ready  = w_gnt[1];
  assign w_xfer     = |w_gnt;
  assign w_xaddr    = w_gnt[1] ? mem_addr : alu_addr;
  assign w_xdata    = w_gnt[1] ? mem_data : alu_data;
  assign w_xfer_inr = w_xfer && vrf_in_range(w_xaddr, VRF_BASE);
  assign w_xidx     = vrf_index(w_xaddr, VRF_BASE);
  assign w_rsv_inr  = vrf_in_range(rsv_addr, VRF_BASE);
  assign w_rsv_idx  = vrf_index(rsv_addr, VRF_BASE);

  // A reservation landing on a register retiring at the same edge is a fresh reservation, not WAW.
  always_comb begin
    w_clr     = '0;
    w_set     = '0;
    w_rsv_err = 1'b0;
    if (w_xfer_inr) w_clr[w_xidx] = 1'b1;
    if (rsv_valid) begin
      if (!w_rsv_inr)                                  w_rsv_err = 1'b1;
      else if (r_busy[w_rsv_idx] && !w_clr[w_rsv_idx]) w_rsv_err = 1'b1;
      else                                             w_set[w_rsv_idx] = 1'b1;
    end
    w_busy_nxt = (r_busy & ~w_clr) | w_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vwe  <= 1'b0;
      r_vwa  <= '0;
      r_vwd  <= '0;
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_vwe  <= w_xfer_inr;
      r_busy <= w_busy_nxt;
      r_err  <= (w_xfer && !w_xfer_inr) || w_rsv_err;
      if (w_xfer_inr) begin
        r_vwa <= w_xaddr;
        r_vwd <= w_xdata;
      end
    end
  end

  assign vwe3     = r_vwe;
  assign vwa3     = r_vwa;
  assign vwd3     = r_vwd;
  assign busy     = r_busy;
  assign err      = r_err;
  assign chk_busy = vrf_in_range(chk_addr, VRF_BASE) ? r_busy[vrf_index(chk_addr, VRF_BASE)] : 1'b0;
endmodule
